// File: rtl/funnel_arbiter.sv
// Round-robin funnel: N requester lanes share one output through a
// one-entry output buffer, with bursts of up to maxBurst beats per grant.
module funnel_arbiter #(
   parameter int unsigned dataWidth   = 32,
   parameter int unsigned funnelWidth = 4,
   parameter int unsigned maxBurst    = 4
) (
   input  logic                             CLK,
   input  logic                             nRST,
   input  logic [funnelWidth-1:0]           in_req,
   input  logic [funnelWidth-1:0]           in_enq__ENA,
   input  logic [funnelWidth*dataWidth-1:0] in_enq_v,
   output logic [funnelWidth-1:0]           in_enq__RDY,
   output logic                             out_enq__ENA,
   output logic [dataWidth-1:0]             out_enq_v,
   input  logic                             out_enq__RDY,
   output logic [$clog2(funnelWidth)-1:0]   grant,
   output logic                             busy,
   output logic                             err
);

   localparam int unsigned GW = $clog2(funnelWidth);
   localparam int unsigned CW = $clog2(maxBurst + 1);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t                 state_q, state_d;
   logic [GW-1:0]          grant_q, grant_d;
   logic [GW-1:0]          ptr_q, ptr_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic                   ob_valid_q, ob_valid_d;
   logic [dataWidth-1:0]   ob_data_q, ob_data_d;
   logic                   err_q, err_d;

   logic                   lane_open_c;
   logic                   accept_c;
   logic                   out_fire_c;
   logic [funnelWidth-1:0] rdy_c;
   logic [dataWidth-1:0]   lane_data_c;
   logic [GW-1:0]          next_lane_c;
   logic [CW-1:0]          cnt_inc_c;
   int unsigned            idx;

   // Handshake decode, payload select and round-robin search
   always_comb begin
      lane_open_c = (state_q == GRANT) && (!ob_valid_q || out_enq__RDY);
      rdy_c       = '0;
      if (lane_open_c) rdy_c[grant_q] = 1'b1;
      accept_c    = lane_open_c && in_enq__ENA[grant_q];
      out_fire_c  = ob_valid_q && out_enq__RDY;
      cnt_inc_c   = cnt_q + CW'(1);

      lane_data_c = '0;
      for (int unsigned i = 0; i < funnelWidth; i++) begin
         if (grant_q == GW'(i)) lane_data_c = in_enq_v[i*dataWidth +: dataWidth];
      end

      // Scan from farthest to nearest so the lane right after ptr wins
      next_lane_c = ptr_q;
      idx         = 0;
      for (int unsigned k = funnelWidth; k != 0; k--) begin
         idx = (32'(ptr_q) + k) % funnelWidth;
         if (in_req[GW'(idx)]) next_lane_c = GW'(idx);
      end
   end

   // Next-state: arbitration, burst counting, output buffer, error flag
   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      ptr_d      = ptr_q;
      cnt_d      = cnt_q;
      ob_valid_d = ob_valid_q;
      ob_data_d  = ob_data_q;
      err_d      = err_q | (|(in_enq__ENA & ~rdy_c));

      if (accept_c) begin
         ob_data_d  = lane_data_c;
         ob_valid_d = 1'b1;
      end else if (out_fire_c) begin
         ob_valid_d = 1'b0;
      end

      case (state_q)
         IDLE: begin
            if (|in_req) begin
               state_d = GRANT;
               grant_d = next_lane_c;
               cnt_d   = '0;
            end
         end
         GRANT: begin
            if (accept_c) begin
               cnt_d = cnt_inc_c;
               if (cnt_inc_c == CW'(maxBurst)) begin
                  state_d = IDLE;
                  ptr_d   = grant_q;
               end
            end else if (!in_req[grant_q]) begin
               state_d = IDLE;
               ptr_d   = grant_q;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State registers
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q    <= IDLE;
         grant_q    <= '0;
         ptr_q      <= GW'(funnelWidth - 1);
         cnt_q      <= '0;
         ob_valid_q <= 1'b0;
         ob_data_q  <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         ptr_q      <= ptr_d;
         cnt_q      <= cnt_d;
         ob_valid_q <= ob_valid_d;
         ob_data_q  <= ob_data_d;
         err_q      <= err_d;
      end
   end

   assign in_enq__RDY  = rdy_c;
   assign out_enq__ENA = out_fire_c;
   assign out_enq_v    = ob_data_q;
   assign grant        = grant_q;
   assign busy         = (state_q == GRANT);
   assign err          = err_q;

endmodule

// File: tb/tb_funnel_arbiter.sv
// Directed bench for funnel_arbiter: a 4-lane/4-beat instance (a) and a
// 4-lane/1-beat instance (b), with payload scoreboards per instance.
module tb_funnel_arbiter;

   logic         CLK;
   logic         nRST;

   logic [3:0]   req_a, ena_a, rdy_a;
   logic [127:0] v_a;
   logic         oena_a, ordy_a, busy_a, err_a;
   logic [31:0]  ov_a;
   logic [1:0]   grant_a;

   logic [3:0]   req_b, ena_b, rdy_b;
   logic [127:0] v_b;
   logic         oena_b, ordy_b, busy_b, err_b;
   logic [31:0]  ov_b;
   logic [1:0]   grant_b;

   logic [31:0]  q_a[$];
   logic [31:0]  q_b[$];
   int           n_checks;
   int           n_errors;

   funnel_arbiter #(.dataWidth(32), .funnelWidth(4), .maxBurst(4)) u_dut_a (
      .CLK(CLK), .nRST(nRST),
      .in_req(req_a), .in_enq__ENA(ena_a), .in_enq_v(v_a), .in_enq__RDY(rdy_a),
      .out_enq__ENA(oena_a), .out_enq_v(ov_a), .out_enq__RDY(ordy_a),
      .grant(grant_a), .busy(busy_a), .err(err_a)
   );

   funnel_arbiter #(.dataWidth(32), .funnelWidth(4), .maxBurst(1)) u_dut_b (
      .CLK(CLK), .nRST(nRST),
      .in_req(req_b), .in_enq__ENA(ena_b), .in_enq_v(v_b), .in_enq__RDY(rdy_b),
      .out_enq__ENA(oena_b), .out_enq_v(ov_b), .out_enq__RDY(ordy_b),
      .grant(grant_b), .busy(busy_b), .err(err_b)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Compare output beats against the scoreboards, then move to next negedge
   task automatic cyc();
      #1;
      if (oena_a === 1'b1) begin
         if (q_a.size() == 0) chk("a_unexpected_beat", 32'(oena_a), 32'h0);
         else                 chk("a_out_data", ov_a, q_a.pop_front());
      end
      if (oena_b === 1'b1) begin
         if (q_b.size() == 0) chk("b_unexpected_beat", 32'(oena_b), 32'h0);
         else                 chk("b_out_data", ov_b, q_b.pop_front());
      end
      @(negedge CLK);
   endtask

   task automatic beat_a(input int lane, input logic [31:0] d);
      ena_a = 4'(1 << lane);
      v_a[lane*32 +: 32] = d;
      q_a.push_back(d);
   endtask

   task automatic beat_b(input int lane, input logic [31:0] d);
      ena_b = 4'(1 << lane);
      v_b[lane*32 +: 32] = d;
      q_b.push_back(d);
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      nRST   = 1'b0;
      req_a  = '0; ena_a = '0; v_a = '0; ordy_a = 1'b1;
      req_b  = '0; ena_b = '0; v_b = '0; ordy_b = 1'b1;

      // Reset state
      #1;
      chk("rst_busy",  32'(busy_a),  32'h0);
      chk("rst_rdy",   32'(rdy_a),   32'h0);
      chk("rst_oena",  32'(oena_a),  32'h0);
      chk("rst_err",   32'(err_a),   32'h0);
      chk("rst_grant", 32'(grant_a), 32'h0);
      @(negedge CLK);
      @(negedge CLK);
      nRST = 1'b1;

      // Single lane, two beats, release on req drop
      req_a = 4'b0010;
      #1; chk("t1_idle_busy", 32'(busy_a), 32'h0);
      cyc();
      beat_a(1, 32'hA1);
      #1;
      chk("t1_grant", 32'(grant_a), 32'h1);
      chk("t1_busy",  32'(busy_a),  32'h1);
      chk("t1_rdy",   32'(rdy_a),   32'h2);
      cyc();
      beat_a(1, 32'hA2);
      #1; chk("t1_rdy2", 32'(rdy_a), 32'h2);
      cyc();
      ena_a = '0; req_a = '0;
      cyc();
      #1;
      chk("t1_released", 32'(busy_a), 32'h0);
      chk("t1_rdy_off",  32'(rdy_a),  32'h0);
      cyc();

      // Reset, then all lanes requesting: grants 0,1,2,3,0 with bubbles
      nRST = 1'b0;
      #1; chk("t2_rst_busy", 32'(busy_a), 32'h0);
      @(negedge CLK);
      nRST = 1'b1;
      req_a = 4'b1111;
      cyc();
      for (int g = 0; g < 5; g++) begin
         for (int b = 0; b < 4; b++) begin
            beat_a(g % 4, 32'hC000_0000 | 32'(g << 8) | 32'(b));
            #1;
            chk("t2_grant", 32'(grant_a), 32'(g % 4));
            chk("t2_busy",  32'(busy_a),  32'h1);
            chk("t2_rdy",   32'(rdy_a),   32'(1) << (g % 4));
            cyc();
         end
         ena_a = '0;
         #1; chk("t2_bubble", 32'(busy_a), 32'h0);
         cyc();
      end
      req_a = '0;
      cyc();
      cyc();

      // Backpressure for 3 cycles mid-burst on lane 0
      req_a = 4'b0001;
      cyc();
      beat_a(0, 32'hD0);
      #1;
      chk("t3_grant", 32'(grant_a), 32'h0);
      chk("t3_rdy",   32'(rdy_a),   32'h1);
      cyc();
      ena_a = '0; ordy_a = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("t3_bp_rdy",   32'(rdy_a),   32'h0);
         chk("t3_bp_oena",  32'(oena_a),  32'h0);
         chk("t3_bp_data",  ov_a,         32'hD0);
         chk("t3_bp_grant", 32'(grant_a), 32'h0);
         cyc();
      end
      ordy_a = 1'b1;
      beat_a(0, 32'hD1);
      #1; chk("t3_resume_rdy", 32'(rdy_a), 32'h1);
      cyc();
      ena_a = '0; req_a = '0;
      cyc();
      #1; chk("t3_err", 32'(err_a), 32'h0);
      cyc();

      // Lane 2 enqueues illegally while lane 0 holds the grant
      req_a = 4'b0001;
      cyc();
      ena_a = 4'b0101;
      v_a[0*32 +: 32] = 32'hE0;
      v_a[2*32 +: 32] = 32'hDEAD_BEEF;
      q_a.push_back(32'hE0);
      #1; chk("t4_rdy", 32'(rdy_a), 32'h1);
      cyc();
      beat_a(0, 32'hE1);
      #1;
      chk("t4_err",   32'(err_a),   32'h1);
      chk("t4_grant", 32'(grant_a), 32'h0);
      chk("t4_busy",  32'(busy_a),  32'h1);
      cyc();
      ena_a = '0; req_a = '0;
      cyc();
      #1; chk("t4_err_sticky", 32'(err_a), 32'h1);
      cyc();

      // Reset mid-burst with a buffered beat (lane 2 granted first)
      req_a = 4'b0101;
      cyc();
      ena_a = 4'b0100;
      v_a[2*32 +: 32] = 32'hF0;
      #1; chk("t5_grant", 32'(grant_a), 32'h2);
      cyc();
      ena_a = '0;
      #1; chk("t5_pre_oena", 32'(oena_a), 32'h1);
      nRST = 1'b0;
      #1;
      chk("t5_oena",  32'(oena_a),  32'h0);
      chk("t5_busy",  32'(busy_a),  32'h0);
      chk("t5_rdy",   32'(rdy_a),   32'h0);
      chk("t5_err",   32'(err_a),   32'h0);
      chk("t5_grant_rst", 32'(grant_a), 32'h0);
      @(negedge CLK);
      #1; chk("t5_hold_oena", 32'(oena_a), 32'h0);
      @(negedge CLK);
      nRST = 1'b1;
      cyc();
      #1;
      chk("t5_regrant", 32'(grant_a), 32'h0);
      chk("t5_rebusy",  32'(busy_a),  32'h1);
      req_a = '0;
      cyc();
      cyc();

      // maxBurst == 1: lanes 0 and 3 alternate single beats
      req_b = 4'b1001;
      cyc();
      for (int i = 0; i < 4; i++) begin
         beat_b((i % 2 == 1) ? 3 : 0, 32'hB0 + 32'(i));
         #1;
         chk("t6_grant", 32'(grant_b), (i % 2 == 1) ? 32'h3 : 32'h0);
         chk("t6_busy",  32'(busy_b),  32'h1);
         chk("t6_rdy",   32'(rdy_b),   (i % 2 == 1) ? 32'h8 : 32'h1);
         cyc();
         ena_b = '0;
         #1; chk("t6_bubble", 32'(busy_b), 32'h0);
         cyc();
      end
      req_b = '0;
      cyc();
      cyc();

      chk("a_sb_empty", 32'(q_a.size()), 32'h0);
      chk("b_sb_empty", 32'(q_b.size()), 32'h0);
      chk("b_err",      32'(err_b),      32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/funnel_arbiter.md
FUNNEL_ARBITER -- requirements
Module: funnel_arbiter

Interface
REQ-001 Parameter dataWidth, default 32: payload width of each lane and of the output.
REQ-002 Parameter funnelWidth, default 4: number of requester lanes, 2..8.
REQ-003 Parameter maxBurst, default 4: maximum beats per grant, 1..16.
REQ-004 CLK  input  1  sole clock; all state on rising edge.
REQ-005 nRST  input  1  reset; asynchronous assertion, active low.
REQ-006 in_req  input  funnelWidth  bit i high: lane i has data pending.
REQ-007 in_enq__ENA  input  funnelWidth  bit i: lane i enqueues this cycle; legal only while in_enq__RDY[i] high.
REQ-008 in_enq$v  input  funnelWidth*dataWidth  lane i payload in bits [i*dataWidth +: dataWidth].
REQ-009 in_enq__RDY  output  funnelWidth  bit i: lane i may enqueue this cycle.
REQ-010 out$enq__ENA  output  1  output beat transferred this cycle.
REQ-011 out$enq$v  output  dataWidth  output payload.
REQ-012 out$enq__RDY  input  1  downstream can accept.
REQ-013 grant  output  clog2(funnelWidth)  currently granted lane; valid when busy high.
REQ-014 busy  output  1  high in GRANT state.
REQ-015 err  output  1  sticky protocol-violation flag.

Function
REQ-016 States: IDLE, GRANT; registers: state, grant, ptr (last released lane), beat count, output buffer (obValid, obData), err.
REQ-017 IDLE with any in_req bit high: next cycle GRANT, grant = first set in_req bit searching ptr+1, ptr+2, ... modulo funnelWidth; beat count cleared.
REQ-018 IDLE with in_req all zero: remain IDLE.
REQ-019 in_enq__RDY[i] = (state==GRANT) && (grant==i) && (!obValid || out$enq__RDY); all other bits 0 (combinational).
REQ-020 Accepted beat (in_enq__ENA[grant] && in_enq__RDY[grant]): obData <= lane payload, obValid <= 1, beat count +1.
REQ-021 out$enq__ENA = obValid && out$enq__RDY; out$enq$v = obData; obValid clears on transfer unless reloaded same cycle.
REQ-022 Latency: accepted beat appears on out$enq$v next cycle; req-to-first-RDY one cycle from IDLE.
REQ-023 Release (GRANT -> IDLE, ptr <= grant) when: accepted beat makes count equal maxBurst, or in_req[grant] low with no beat that cycle.
REQ-024 Release always passes through one IDLE cycle (one-cycle bubble between grants); buffered beat still drains during IDLE.
REQ-025 Round-robin fairness: released lane is lowest priority at next arbitration; with all lanes requesting, grants rotate 0,1,...,funnelWidth-1,0.
REQ-026 in_enq__ENA[i] high while in_enq__RDY[i] low: payload discarded, err <= 1 (sticky until reset), state unaffected.
REQ-027 Simultaneous drain and load of buffer in one cycle permitted; throughput one beat per cycle while out$enq__RDY held high.
REQ-028 out$enq__RDY low holds obData stable and blocks further accepts; beat count and grant hold.
REQ-029 maxBurst==1: every grant releases after one beat.

Reset
REQ-030 nRST low asynchronously forces: state IDLE, grant 0, ptr funnelWidth-1, beat count 0, obValid 0, err 0.
REQ-031 During and after reset until first arbitration: in_enq__RDY all 0, out$enq__ENA 0, busy 0.
REQ-032 Reset mid-burst discards buffered beat; first grant after reset goes to lowest-index requesting lane.

Verification
REQ-033 Single lane: in_req=0b0010, lane 1 sends 0xA1,0xA2, out$enq__RDY=1 -> grant=1 one cycle after req, out shows 0xA1,0xA2 on consecutive cycles, release after req drops.
REQ-034 All four lanes requesting continuously, maxBurst=4 -> grant sequence 0,1,2,3,0, each 4 beats then 1 idle cycle, no beat lost or reordered.
REQ-035 Backpressure: out$enq__RDY=0 for 3 cycles mid-burst -> in_enq__RDY[grant]=0, out$enq$v stable, no duplication; resumes on RDY=1.
REQ-036 Lane 2 asserts in_enq__ENA while grant=0 -> err=1, lane 2 payload absent from output, lane 0 burst unaffected.
REQ-037 nRST low mid-burst with obValid=1 -> outputs cleared immediately, no out$enq__ENA; after release lane 0 granted first if requesting.
REQ-038 maxBurst=1, lanes 0 and 3 requesting -> alternate single beats 0,3,0,3 with idle cycle between.
